// File: rtl/matmul_pkg.sv
// Shared definitions for the 3x3 matrix-multiply sequencing controller.
// Holds matrix geometry, the controller state encoding and the result width helper.
package matmul_pkg;

   localparam int MAT_N     = 3;
   localparam int MAT_ELEMS = MAT_N * MAT_N;

   typedef enum logic [3:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      START,
      WAIT_CALC,
      RD_REQ,
      RD_CAP,
      SEND,
      WAIT_TX_HI,
      WAIT_TX_LO
   } ctrl_state_t;

   function automatic int res_width(input int data_width);
      return 2 * data_width;
   endfunction

endpackage

// File: rtl/matmul_tx_handshake.sv
// One-byte send handshake towards uart_tx: waits for idle, pulses tx_start,
// then waits for busy to rise (or TXACK_CYCLES to pass) and fall again.
module matmul_tx_handshake
   import matmul_pkg::*;
#(
   parameter int TXACK_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic tx_busy,
   output logic tx_start,
   output logic done
);

   localparam int AW = $clog2(TXACK_CYCLES + 1);

   ctrl_state_t       hs;
   logic [AW-1:0]     ack_cnt;

   // Gated on the live busy level so a start can never overlap a busy UART.
   assign tx_start = (hs == SEND) && !tx_busy;
   assign done     = (hs == WAIT_TX_LO) && !tx_busy;

   always_ff @(posedge clk) begin
      if (!rst) begin
         hs      <= IDLE;
         ack_cnt <= '0;
      end else begin
         case (hs)
            IDLE:       if (req) hs <= SEND;
            SEND:       if (!tx_busy) begin
                           hs      <= WAIT_TX_HI;
                           ack_cnt <= '0;
                        end
            WAIT_TX_HI: if (tx_busy || ack_cnt == AW'(TXACK_CYCLES - 1)) hs <= WAIT_TX_LO;
                        else ack_cnt <= ack_cnt + 1'b1;
            WAIT_TX_LO: if (!tx_busy) hs <= IDLE;
            default:    hs <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Frames 18 RX bytes into the A/B operand stores, starts the datapath, then
// streams the 9 results back out through uart_tx one byte at a time.
module matmul_seq_ctrl
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TXACK_CYCLES   = 4,
   localparam int RW            = res_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_ready,
   output logic                  op_wr_en,
   output logic                  op_sel_b,
   output logic [3:0]            op_addr,
   output logic [DATA_WIDTH-1:0] op_data,
   output logic                  calc_start,
   input  logic                  calc_done,
   output logic [3:0]            res_addr,
   input  logic [RW-1:0]         res_data,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   input  logic                  tx_busy,
   output logic                  busy,
   output logic                  range_err,
   output logic                  timeout_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   ctrl_state_t   state;
   logic [3:0]    count;
   logic [TW-1:0] tmo_cnt;
   logic          loading;
   logic          wr;
   logic          hs_done;

   // Operand writes happen in the cycle the byte arrives, so they are decoded
   // straight from rx_ready; everything else below is registered.
   assign loading  = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);
   assign wr       = rst && rx_ready && loading;
   assign op_wr_en = wr;
   assign op_sel_b = wr && (state == LOAD_B);
   assign op_addr  = wr ? count : '0;
   assign op_data  = wr ? rx_data[DATA_WIDTH-1:0] : '0;
   assign busy     = (state != IDLE);

   matmul_tx_handshake #(.TXACK_CYCLES(TXACK_CYCLES)) u_tx_hs (
      .clk      (clk),
      .rst      (rst),
      .req      (state == SEND),
      .tx_busy  (tx_busy),
      .tx_start (tx_start),
      .done     (hs_done)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         count       <= '0;
         tmo_cnt     <= '0;
         calc_start  <= 1'b0;
         res_addr    <= '0;
         tx_data     <= '0;
         range_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         calc_start  <= 1'b0;
         timeout_err <= 1'b0;
         if (wr && (rx_data >> DATA_WIDTH) != 8'd0) range_err <= 1'b1;

         case (state)
            IDLE: if (rx_ready) begin
               state   <= LOAD_A;
               count   <= 4'd1;
               tmo_cnt <= '0;
            end
            LOAD_A, LOAD_B: begin
               // A byte landing on the expiry cycle wins over the timeout.
               if (rx_ready) begin
                  tmo_cnt <= '0;
                  if (count == 4'(MAT_ELEMS - 1)) begin
                     count <= '0;
                     if (state == LOAD_A) begin
                        state <= LOAD_B;
                     end else begin
                        state      <= START;
                        calc_start <= 1'b1;
                     end
                  end else begin
                     count <= count + 1'b1;
                  end
               end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  state       <= IDLE;
                  count       <= '0;
                  tmo_cnt     <= '0;
                  timeout_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            START:     state <= WAIT_CALC;
            WAIT_CALC: if (calc_done) begin
               state    <= RD_REQ;
               res_addr <= '0;
            end
            RD_REQ:    state <= RD_CAP;
            RD_CAP: begin
               tx_data <= 8'(res_data);
               state   <= SEND;
            end
            SEND: if (hs_done) begin
               if (res_addr == 4'(MAT_ELEMS - 1)) begin
                  state <= IDLE;
               end else begin
                  res_addr <= res_addr + 1'b1;
                  state    <= RD_REQ;
               end
            end
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: drives randomized and directed 18-byte frames
// through a datapath/UART environment and checks writes, results and handshakes.
module tb_matmul_seq_ctrl;

   localparam int DW  = 4;
   localparam int TMO = 100;
   localparam int TXA = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_ready = 1'b0;
   logic       op_wr_en, op_sel_b, calc_start, tx_start, busy, range_err, timeout_err;
   logic [3:0] op_addr, res_addr;
   logic [DW-1:0] op_data;
   logic [7:0] tx_data;
   logic       calc_done = 1'b0;
   logic [7:0] res_data = 8'h00;
   logic       tx_busy;

   matmul_seq_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO), .TXACK_CYCLES(TXA)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
      .op_wr_en(op_wr_en), .op_sel_b(op_sel_b), .op_addr(op_addr), .op_data(op_data),
      .calc_start(calc_start), .calc_done(calc_done), .res_addr(res_addr), .res_data(res_data),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy),
      .range_err(range_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- environment: datapath and UART ----------------
   logic [3:0] sa[9];
   logic [3:0] sb[9];
   int         dcnt = 0;
   int         calc_lat = 5;
   logic       ubusy = 1'b0;
   int         ucnt = 0;
   int         uart_len = 4;
   logic       uart_mode = 1'b1;
   logic       force_busy = 1'b0;

   assign tx_busy = ubusy | force_busy;

   function automatic logic [7:0] dp_res(input int idx);
      int s = 0;
      for (int k = 0; k < 3; k++) s += int'(sa[(idx / 3) * 3 + k]) * int'(sb[k * 3 + idx % 3]);
      return 8'(s);
   endfunction

   always @(posedge clk) begin
      if (op_wr_en && op_addr < 4'd9) begin
         if (op_sel_b) sb[op_addr] <= op_data;
         else          sa[op_addr] <= op_data;
      end
      if (!rst) begin
         dcnt      <= 0;
         calc_done <= 1'b0;
      end else begin
         calc_done <= (dcnt == 1);
         if (calc_start)     dcnt <= calc_lat;
         else if (dcnt != 0) dcnt <= dcnt - 1;
      end
      res_data <= (res_addr < 4'd9) ? dp_res(int'(res_addr)) : 8'h00;
   end

   // UART is not reset: an in-flight byte keeps it busy across a controller reset.
   always @(posedge clk) begin
      if (tx_start && uart_mode) begin
         ubusy <= 1'b1;
         ucnt  <= uart_len;
      end else if (ucnt > 1) begin
         ucnt <= ucnt - 1;
      end else if (ucnt == 1) begin
         ucnt  <= 0;
         ubusy <= 1'b0;
      end
   end

   // ---------------- monitor ----------------
   logic [8:0] wr_q[$];
   logic [7:0] tx_q[$];
   int         n_cs = 0, n_tmo = 0, n_viol = 0;

   always @(negedge clk) begin
      if (op_wr_en) wr_q.push_back({op_sel_b, op_addr, op_data});
      if (tx_start) begin
         tx_q.push_back(tx_data);
         if (tx_busy) n_viol++;
      end
      if (calc_start)  n_cs++;
      if (timeout_err) n_tmo++;
   end

   // ---------------- reference model ----------------
   logic [7:0] fa[9];
   logic [7:0] fb[9];

   function automatic logic [7:0] ref_c(input int i);
      int s = 0;
      for (int k = 0; k < 3; k++)
         s += int'(fa[(i / 3) * 3 + k] & 8'h0F) * int'(fb[k * 3 + i % 3] & 8'h0F);
      return 8'(s);
   endfunction

   function automatic logic [8:0] ref_wr(input int i);
      logic [7:0] b;
      b = (i < 9) ? fa[i] : fb[i - 9];
      return {(i >= 9), 4'(i % 9), b[3:0]};
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data  = b;
      rx_ready = 1'b1;
      @(posedge clk); #1;
      rx_ready = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic send_bytes(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) send_byte((i < 9) ? fa[i] : fb[i - 9]);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 9; i++) begin
         fa[i] = 8'($urandom_range(0, 15));
         fb[i] = 8'($urandom_range(0, 15));
      end
   endtask

   task automatic clear_logs();
      wr_q.delete();
      tx_q.delete();
      n_cs = 0; n_tmo = 0; n_viol = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst      = 1'b0;
      rx_ready = 1'b1;
      rx_data  = 8'hFF;
      @(posedge clk); @(negedge clk);
      chk("reset_outs", 32'({op_wr_en, op_sel_b, op_addr, op_data, calc_start, res_addr,
                             tx_data, tx_start, busy, range_err, timeout_err}), 32'd0);
      @(posedge clk); #1;
      rst      = 1'b1;
      rx_ready = 1'b0;
   endtask

   task automatic check_frame(input string tag);
      int t = 0;
      while (tx_q.size() < 9 && t < 3000) begin @(posedge clk); t++; end
      t = 0;
      while (busy && t < 200) begin @(negedge clk); t++; end
      @(negedge clk);
      chk({tag, "_ntx"}, tx_q.size(), 9);
      chk({tag, "_idle"}, busy, 1'b0);
      chk({tag, "_nwr"}, wr_q.size(), 18);
      for (int i = 0; i < 18; i++)
         if (i < wr_q.size()) chk($sformatf("%s_wr%0d", tag, i), wr_q[i], ref_wr(i));
      chk({tag, "_calc_start"}, n_cs, 1);
      for (int j = 0; j < 9; j++)
         if (j < tx_q.size()) chk($sformatf("%s_tx%0d", tag, j), tx_q[j], ref_c(j));
      chk({tag, "_start_while_busy"}, n_viol, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hit;
      do_reset();

      // nominal: A = 1..9, B = identity
      clear_logs();
      for (int i = 0; i < 9; i++) begin
         fa[i] = 8'(i + 1);
         fb[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
      end
      send_bytes(0, 17);
      check_frame("nominal");
      chk("nominal_tmo", n_tmo, 0);
      chk("nominal_range", range_err, 1'b0);

      // largest product through the 8-bit path: 15 * 15 = 225 in every element
      clear_logs();
      for (int i = 0; i < 9; i++) begin
         fa[i] = 8'd15;
         fb[i] = (i % 4 == 0) ? 8'd15 : 8'd0;
      end
      send_bytes(0, 17);
      check_frame("max");
      if (tx_q.size() > 0) chk("max_e1", tx_q[0], 8'hE1);

      // random frames with random UART byte times
      for (int r = 0; r < 2; r++) begin
         clear_logs();
         fill_rand();
         uart_len = $urandom_range(2, 9);
         send_bytes(0, 17);
         check_frame($sformatf("rand%0d", r));
      end

      // out-of-range operand byte at A[4]
      do_reset();
      clear_logs();
      fill_rand();
      fa[4] = 8'h1F;
      send_bytes(0, 3);
      chk("range_before", range_err, 1'b0);
      send_byte(fa[4]);
      @(negedge clk);
      chk("range_set", range_err, 1'b1);
      send_bytes(5, 17);
      chk("range_mid", range_err, 1'b1);
      check_frame("range");
      chk("range_sticky", range_err, 1'b1);

      // timeout after 5 bytes
      do_reset();
      clear_logs();
      fill_rand();
      send_bytes(0, 4);
      hit = 0;
      for (int k = 1; k <= 130 && hit == 0; k++) begin
         @(posedge clk); @(negedge clk);
         if (timeout_err) hit = k;
      end
      chk("tmo_cycle", hit, TMO);
      @(negedge clk);
      chk("tmo_pulse_width", timeout_err, 1'b0);
      chk("tmo_idle", busy, 1'b0);
      chk("tmo_count", n_tmo, 1);
      clear_logs();
      fill_rand();
      send_bytes(0, 17);
      check_frame("after_tmo");

      // byte arriving exactly on the expiry cycle counts as data
      clear_logs();
      fill_rand();
      send_bytes(0, 2);
      repeat (TMO - 2) @(posedge clk);
      send_bytes(3, 17);
      check_frame("tmo_edge");
      chk("tmo_edge_none", n_tmo, 0);

      // UART held busy while the first result is pending
      clear_logs();
      fill_rand();
      send_bytes(0, 17);
      force_busy = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      chk("hold_no_start", tx_q.size(), 0);
      chk("hold_busy", busy, 1'b1);
      force_busy = 1'b0;
      check_frame("hold");

      // UART that never reports busy
      uart_mode = 1'b0;
      clear_logs();
      fill_rand();
      send_bytes(0, 17);
      check_frame("nobusy");
      uart_mode = 1'b1;

      // reset while waiting for the datapath
      calc_lat = 40;
      clear_logs();
      fill_rand();
      send_bytes(0, 17);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("wcalc_busy", busy, 1'b1);
      do_reset();
      calc_lat = 5;
      clear_logs();
      fill_rand();
      send_bytes(0, 17);
      check_frame("post_rst_calc");

      // reset in the middle of result 4
      clear_logs();
      fill_rand();
      send_bytes(0, 17);
      hit = 0;
      while (tx_q.size() < 4 && hit < 2000) begin @(posedge clk); hit++; end
      chk("mid_tx_reached", 32'(tx_q.size() >= 4), 32'd1);
      do_reset();
      clear_logs();
      fill_rand();
      send_bytes(0, 17);
      check_frame("post_rst_tx");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
